// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between the pipeline sequencer and its clients.
// The master side (execute, bus arbiter, interrupt controller, debug module)
// raises requests; the slave side (pipe_ctrl) returns hold/flush/redirect.
interface pipe_ctrl_if;
    logic        jump_req_i;
    logic [31:0] jump_addr_i;
    logic        int_assert_i;
    logic [31:0] int_addr_i;
    logic        div_busy_i;
    logic        bus_hold_req_i;
    logic        jtag_halt_req_i;
    logic [2:0]  hold_flag_o;
    logic [2:0]  flush_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        halted_o;
    logic        bus_timeout_o;

    modport master (
        output jump_req_i, jump_addr_i, int_assert_i, int_addr_i,
               div_busy_i, bus_hold_req_i, jtag_halt_req_i,
        input  hold_flag_o, flush_flag_o, jump_flag_o, jump_addr_o,
               halted_o, bus_timeout_o
    );

    modport slave (
        input  jump_req_i, jump_addr_i, int_assert_i, int_addr_i,
               div_busy_i, bus_hold_req_i, jtag_halt_req_i,
        output hold_flag_o, flush_flag_o, jump_flag_o, jump_addr_o,
               halted_o, bus_timeout_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: resolves redirect/stall/halt requests by fixed
// priority into registered hold/flush codes, a PC redirect strobe, a debug
// halt state and a bus-stall watchdog. All outputs are registered.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,    // 1..7
    parameter int BUS_TIMEOUT  = 1024  // 2..65535
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  ctrl
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [2:0] CODE_NONE = 3'd0;
    localparam logic [2:0] CODE_PC   = 3'd1;
    localparam logic [2:0] CODE_ID   = 3'd3;

    localparam logic [2:0]  FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [15:0] BUS_LAST     = 16'(BUS_TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [15:0] bus_cnt_q, bus_cnt_d;
    logic [2:0]  hold_q, hold_d;
    logic [2:0]  flush_q, flush_d;
    logic        jump_flag_q, jump_flag_d;
    logic [31:0] jump_addr_q, jump_addr_d;
    logic        halted_q, halted_d;
    logic        timeout_q, timeout_d;

    logic        redirect;
    logic [31:0] redirect_addr;

    // Interrupt outranks a jump for both the request and the target.
    assign redirect      = ctrl.int_assert_i | ctrl.jump_req_i;
    assign redirect_addr = ctrl.int_assert_i ? ctrl.int_addr_i : ctrl.jump_addr_i;

    // Sequencer next-state: redirect, flush drain, halt, then stalls.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; that is what keeps this block from inferring latches.
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        hold_d      = CODE_NONE;
        flush_d     = CODE_NONE;
        jump_flag_d = 1'b0;
        jump_addr_d = jump_addr_q;
        halted_d    = 1'b0;

        if (state_q != ST_HALT && redirect) begin
            // New redirect from RUN, or a restart in the middle of a flush.
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_RELOAD;
            flush_d     = CODE_ID;
            jump_flag_d = 1'b1;
            jump_addr_d = redirect_addr;
        end else if (state_q == ST_FLUSH && flush_cnt_q != 3'd0) begin
            // Draining: stalls ignored, halt deferred until the count expires.
            flush_cnt_d = flush_cnt_q - 3'd1;
            flush_d     = CODE_ID;
        end else if (state_q == ST_HALT && ctrl.jtag_halt_req_i) begin
            hold_d   = CODE_ID;
            halted_d = 1'b1;
        end else begin
            // RUN, an expired FLUSH, or HALT being released: evaluate as RUN.
            state_d = ST_RUN;
            if (ctrl.jtag_halt_req_i) begin
                state_d  = ST_HALT;
                hold_d   = CODE_ID;
                halted_d = 1'b1;
            end else if (ctrl.div_busy_i) begin
                hold_d = CODE_ID;
            end else if (ctrl.bus_hold_req_i) begin
                hold_d = CODE_PC;
            end
        end
    end

    // Watchdog: counts consecutive bus stalls seen in RUN, fires and rearms.
    always_comb begin
        bus_cnt_d = bus_cnt_q;
        timeout_d = 1'b0;
        if (!ctrl.bus_hold_req_i) begin
            bus_cnt_d = 16'd0;
        end else if (state_q == ST_RUN) begin
            if (bus_cnt_q >= BUS_LAST) begin
                bus_cnt_d = 16'd0;
                timeout_d = 1'b1;
            end else begin
                bus_cnt_d = bus_cnt_q + 16'd1;
            end
        end
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 3'd0;
            bus_cnt_q   <= 16'd0;
            hold_q      <= CODE_NONE;
            flush_q     <= CODE_NONE;
            jump_flag_q <= 1'b0;
            jump_addr_q <= 32'd0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            bus_cnt_q   <= bus_cnt_d;
            hold_q      <= hold_d;
            flush_q     <= flush_d;
            jump_flag_q <= jump_flag_d;
            jump_addr_q <= jump_addr_d;
            halted_q    <= halted_d;
            timeout_q   <= timeout_d;
        end
    end

    assign ctrl.hold_flag_o   = hold_q;
    assign ctrl.flush_flag_o  = flush_q;
    assign ctrl.jump_flag_o   = jump_flag_q;
    assign ctrl.jump_addr_o   = jump_addr_q;
    assign ctrl.halted_o      = halted_q;
    assign ctrl.bus_timeout_o = timeout_q;

endmodule
